bs_gnrtr_n_rbtr_rr: RTL and testbench
=====================================

Name: bs_gnrtr_n_rbtr_rr

Overview:
- Parametrised successor to the single-bus generator/arbiter.
- Connects DRVS driver FIFOs to one shared bus. An arbiter (round-robin or fixed-priority, selectable at runtime) grants one pending source, pops its head packet and delivers it.
- Delivery is to the addressed destination, or to all other drivers on broadcast.
- New relative to the previous generation: receiver backpressure, a delivery timeout, invalid-ID drop, and error/drop counters for the scoreboard.

Parameters:
- PCKG_SZ, 16: packet width in bits.
- DRVS, 8: number of drivers, 2..(2^ID_W - 1).
- ID_W, 8: width of the destination ID field, D[PCKG_SZ-1 -: ID_W].
- BCAST, 8'hFF: broadcast ID value.
- TIMEOUT, 64: maximum cycles a packet may wait on backpressure before it is dropped.
- CNT_W, 16: drop counter width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- prio_mode  in  1  0 = round-robin, 1 = fixed priority (lowest index wins).
- pndng  in  DRVS  per-driver FIFO not empty.
- D_pop  in  DRVS*PCKG_SZ  per-driver FIFO head data, first-word-fall-through, slice i = driver i.
- pop  out  DRVS  one-cycle dequeue strobe to the granted driver.
- full  in  DRVS  per-receiver backpressure; 1 = cannot accept a push.
- push  out  DRVS  one-cycle write strobe, one bit per receiver.
- D_push  out  PCKG_SZ  shared bus data, common to all receivers.
- busy  out  1  high in any state other than IDLE.
- err_drop  out  1  one-cycle pulse when a packet is dropped (invalid ID or timeout).
- drop_cnt  out  CNT_W  saturating count of dropped packets.

Behaviour:
- Reset (sync, has priority over all else):
  - pop = 0, push = 0, D_push = 0, busy = 0, err_drop = 0, drop_cnt = 0.
  - RR pointer = 0, state = IDLE, timeout counter = 0.
- Outputs: all outputs are registered.
- FSM states: IDLE, POP, DELIVER.
- IDLE:
  - If pndng == 0, stay in IDLE.
  - Otherwise select grant g:
    - RR: first set bit at or above the pointer, wrapping from DRVS-1 to 0.
    - Fixed: lowest set index.
  - Go to POP.
  - The RR pointer is updated to (g+1) mod DRVS only when prio_mode = 0. It does not change while fixed priority is active.
- POP:
  - pop[g] = 1 for exactly one cycle.
  - D_pop slice g is captured into the packet register in the same cycle.
  - Decode dest = pkt[PCKG_SZ-1 -: ID_W]:
    - dest == BCAST: mask = all ones except bit g.
    - dest < DRVS: mask = one-hot(dest). A self-addressed packet (dest == g) is delivered to g.
    - Otherwise: invalid. Pulse err_drop next cycle, increment drop_cnt, return to IDLE; no push.
  - Valid packet: go to DELIVER. D_push = pkt is valid from the DELIVER cycle and holds its value until the next capture.
- DELIVER:
  - If (mask & full) == 0: push = mask for one cycle, then IDLE.
  - Else increment the timeout counter. When it reaches TIMEOUT, drop the packet: err_drop pulse, drop_cnt + 1, no push, return to IDLE.
  - Broadcast is all-or-nothing: every target must be non-full in the same cycle. There are no partial pushes.
- Latency:
  - pndng rising while in IDLE at cycle N: pop at N+1, push at N+2 with no backpressure.
  - Steady-state throughput: one packet per 3 cycles.
- Counters:
  - drop_cnt saturates at 2^CNT_W - 1.
  - The timeout counter clears on entry to DELIVER.
- pndng is ignored outside IDLE. A source dropping pndng after grant does not matter, because the data was already captured in POP.
- prio_mode changes take effect at the next IDLE arbitration.
- Reset mid-DELIVER: the packet is lost with no push and no drop count. The popped packet is not restored.
- The push and pop vectors are never nonzero in the same cycle.

Test Plan:
- Unicast: PCKG_SZ = 16, DRVS = 8. Driver 2 holds 16'h05AB, full = 0. Expect pop[2] one cycle after pndng[2] is seen in IDLE, then push = 8'b0010_0000 with D_push = 16'h05AB one cycle later; busy high for 2 cycles.
- Broadcast: driver 3 sends 16'hFF12. Expect push = 8'b1111_0111 once. Repeat with full[6] = 1 for 10 cycles: push is delayed exactly 10 cycles, all targets are pushed together, and err_drop stays 0.
- Arbitration: all 8 drivers keep 4 packets each.
  - prio_mode = 0: grant order 0,1,...,7,0,...
  - prio_mode = 1: driver 0 drains all 4 packets before driver 1 is served.
  - Switching the mode mid-stream takes effect at the next IDLE.
- Invalid ID and timeout:
  - Packet 16'h0A00: err_drop pulse, drop_cnt = 1, no push.
  - Packet 16'h0400 with full[4] held high: err_drop pulses after 64 DELIVER cycles, drop_cnt = 2.
- Saturation and reset: CNT_W = 2, 5 invalid packets, drop_cnt = 3. Then assert reset while in DELIVER: next cycle all outputs are 0, state is IDLE, no push, and the RR pointer restarts at driver 0.

Source files
------------

// File: rtl/bs_gnrtr_n_rbtr_rr.sv
// Shared-bus generator/arbiter: grants one pending driver FIFO (round-robin or fixed
// priority), pops its head packet and pushes it to the addressed receiver(s).
module bs_gnrtr_n_rbtr_rr #(
  parameter int              PCKG_SZ = 16,
  parameter int              DRVS    = 8,
  parameter int              ID_W    = 8,
  parameter logic [ID_W-1:0] BCAST   = 8'hFF,
  parameter int              TIMEOUT = 64,
  parameter int              CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    prio_mode,
  input  logic [DRVS-1:0]         pndng,
  input  logic [DRVS*PCKG_SZ-1:0] D_pop,
  output logic [DRVS-1:0]         pop,
  input  logic [DRVS-1:0]         full,
  output logic [DRVS-1:0]         push,
  output logic [PCKG_SZ-1:0]      D_push,
  output logic                    busy,
  output logic                    err_drop,
  output logic [CNT_W-1:0]        drop_cnt,
  output logic [1:0]              dbg_state
);

  localparam int GW = (DRVS > 1) ? $clog2(DRVS) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_POP     = 2'd1,
    ST_DELIVER = 2'd2
  } state_e;

  // Handshake: pop[g] is a one-cycle dequeue strobe, the FWFT head of driver g is
  // consumed at the end of that cycle; push is a one-cycle write strobe issued only
  // in a cycle after every targeted receiver was seen with full == 0.
  state_e              state_q, state_d;
  logic [GW-1:0]       ptr_q, ptr_d;
  logic [GW-1:0]       gnt_q, gnt_d;
  logic [DRVS-1:0]     mask_q, mask_d;
  logic [TW-1:0]       tmo_q, tmo_d;
  logic [DRVS-1:0]     pop_q, pop_d;
  logic [DRVS-1:0]     push_q, push_d;
  logic [PCKG_SZ-1:0]  dpush_q, dpush_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [GW-1:0]       rr_g, fx_g;
  logic                rr_hit;
  logic [PCKG_SZ-1:0]  head;
  logic [ID_W-1:0]     dest;
  logic                dest_bc, dest_ok;
  logic [DRVS-1:0]     dec_mask;
  logic                drop;

  always_comb begin : rr_pick
    int j;
    rr_g   = '0;
    rr_hit = 1'b0;
    j      = 0;
    for (int k = 0; k < DRVS; k++) begin
      j = int'(ptr_q) + k;
      if (j >= DRVS) j = j - DRVS;
      if (!rr_hit && pndng[GW'(j)]) begin
        rr_hit = 1'b1;
        rr_g   = GW'(j);
      end
    end
  end

  always_comb begin : fx_pick
    fx_g = '0;
    for (int k = DRVS - 1; k >= 0; k--) begin
      if (pndng[k]) fx_g = GW'(k);
    end
  end

  assign head     = D_pop[gnt_q*PCKG_SZ +: PCKG_SZ];
  assign dest     = head[PCKG_SZ-1 -: ID_W];
  assign dest_bc  = (dest == BCAST);
  assign dest_ok  = (dest < ID_W'(DRVS));
  assign dec_mask = dest_bc ? ~(DRVS'(1) << gnt_q) : (DRVS'(1) << dest);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    mask_d  = mask_q;
    tmo_d   = tmo_q;
    pop_d   = '0;
    push_d  = '0;
    dpush_d = dpush_q;
    err_d   = 1'b0;
    drop    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|pndng) begin
          gnt_d   = prio_mode ? fx_g : rr_g;
          pop_d   = DRVS'(1) << gnt_d;
          state_d = ST_POP;
          if (!prio_mode) ptr_d = (gnt_d == GW'(DRVS - 1)) ? '0 : gnt_d + GW'(1);
        end
      end
      ST_POP: begin
        dpush_d = head;
        if (dest_bc || dest_ok) begin
          mask_d  = dec_mask;
          tmo_d   = '0;
          state_d = ST_DELIVER;
          if ((dec_mask & full) == '0) push_d = dec_mask;
        end else begin
          drop    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_DELIVER: begin
        // A push visible now closes the transfer; otherwise retry or age out.
        if (|push_q) begin
          state_d = ST_IDLE;
        end else if ((mask_q & full) == '0) begin
          push_d = mask_q;
        end else begin
          tmo_d = tmo_q + TW'(1);
          if (tmo_d >= TW'(TIMEOUT)) begin
            drop    = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    err_d  = drop;
    cnt_d  = (drop && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      mask_q  <= '0;
      tmo_q   <= '0;
      pop_q   <= '0;
      push_q  <= '0;
      dpush_q <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      mask_q  <= mask_d;
      tmo_q   <= tmo_d;
      pop_q   <= pop_d;
      push_q  <= push_d;
      dpush_q <= dpush_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pop       = pop_q;
  assign push      = push_q;
  assign D_push    = dpush_q;
  assign busy      = busy_q;
  assign err_drop  = err_q;
  assign drop_cnt  = cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_bs_gnrtr_n_rbtr_rr.sv
// Directed bench for bs_gnrtr_n_rbtr_rr: vector table for single packets plus
// sequences for backpressure, arbitration order, timeout, saturation and reset.
module tb_bs_gnrtr_n_rbtr_rr;

  localparam int N = 8;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           prio_mode = 1'b0;
  logic [N-1:0]   pndng = '0;
  logic [N*W-1:0] D_pop = '0;
  logic [N-1:0]   full = '0;
  logic [N-1:0]   pop, push;
  logic [W-1:0]   D_push;
  logic           busy, err_drop;
  logic [15:0]    drop_cnt;
  logic [1:0]     dbg_state;
  logic [N-1:0]   pop_s, push_s;
  logic [W-1:0]   D_push_s;
  logic           busy_s, err_drop_s;
  logic [1:0]     drop_cnt_s;
  logic [1:0]     dbg_state_s;

  bs_gnrtr_n_rbtr_rr #(.PCKG_SZ(W), .DRVS(N), .ID_W(8), .BCAST(8'hFF), .TIMEOUT(64), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .prio_mode(prio_mode), .pndng(pndng), .D_pop(D_pop),
    .pop(pop), .full(full), .push(push), .D_push(D_push), .busy(busy),
    .err_drop(err_drop), .drop_cnt(drop_cnt), .dbg_state(dbg_state));

  bs_gnrtr_n_rbtr_rr #(.PCKG_SZ(W), .DRVS(N), .ID_W(8), .BCAST(8'hFF), .TIMEOUT(64), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .prio_mode(prio_mode), .pndng(pndng), .D_pop(D_pop),
    .pop(pop_s), .full(full), .push(push_s), .D_push(D_push_s), .busy(busy_s),
    .err_drop(err_drop_s), .drop_cnt(drop_cnt_s), .dbg_state(dbg_state_s));

  // Clock / reset
  always #5 clk = ~clk;

  // Driver FIFO model: a pop seen in one cycle dequeues at the following negedge,
  // after the DUT has captured the head.
  logic [W-1:0] fq[N][$];
  logic [N-1:0] pend = '0;
  int           overlap = 0;

  always @(negedge clk) begin
    if (pop != '0 && push != '0) overlap++;
    for (int i = 0; i < N; i++) begin
      if (pend[i] && fq[i].size() > 0) void'(fq[i].pop_front());
      pend[i] = pop[i];
      pndng[i] = (fq[i].size() != 0);
      D_pop[i*W +: W] = (fq[i].size() != 0) ? fq[i][0] : '0;
    end
  end

  // Scoreboard
  int         n_cmp = 0;
  int         n_bad = 0;
  int         exp_cnt = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    exp_cnt = 0;
  endtask

  task automatic wait_pop(output int idx, output int cyc);
    idx = -1;
    cyc = 0;
    for (int t = 0; t < 20; t++) begin
      tick();
      cyc++;
      if (pop != '0) begin
        for (int i = 0; i < N; i++) if (pop[i]) idx = i;
        return;
      end
    end
  endtask

  function automatic logic mode_at(input logic mode0, input int sw1, input int sw2, input int k);
    return (k >= sw1 && k < sw2) ? ~mode0 : mode0;
  endfunction

  task automatic arb_run(input string tag, input logic mode0, input int sw1, input int sw2);
    int rem[N];
    int ptr, idx, cyc;
    exp_q.delete();
    ptr = 0;
    for (int i = 0; i < N; i++) rem[i] = 4;
    for (int k = 0; k < 4 * N; k++) begin
      idx = -1;
      if (!mode_at(mode0, sw1, sw2, k)) begin
        for (int j = 0; j < N; j++)
          if (idx < 0 && rem[(ptr + j) % N] > 0) idx = (ptr + j) % N;
        ptr = (idx + 1) % N;
      end else begin
        for (int j = N - 1; j >= 0; j--) if (rem[j] > 0) idx = j;
      end
      rem[idx]--;
      exp_q.push_back(8'(idx));
    end
    prio_mode = mode0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < 4; j++) fq[i].push_back({8'((i + 1) % N), 8'(i * 16 + j)});
    for (int k = 0; k < 4 * N; k++) begin
      wait_pop(idx, cyc);
      check({tag, "_grant"}, 32'(idx), 32'(exp_q.pop_front()));
      if (k > 0) check({tag, "_interval"}, 32'(cyc), 32'd3);
      prio_mode = mode_at(mode0, sw1, sw2, k + 1);
    end
    repeat (4) tick();
  endtask

  typedef struct {
    int         src;
    logic [W-1:0] data;
    logic [N-1:0] full;
    logic [N-1:0] exp_push;
    logic         exp_drop;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int idx, cyc, n, npulse;
    logic seen_push;

    vecs[0] = '{2, 16'h05AB, 8'h00, 8'b0010_0000, 1'b0};
    vecs[1] = '{3, 16'hFF12, 8'h00, 8'b1111_0111, 1'b0};
    vecs[2] = '{5, 16'h0512, 8'h00, 8'b0010_0000, 1'b0};
    vecs[3] = '{0, 16'h0700, 8'h00, 8'b1000_0000, 1'b0};
    vecs[4] = '{7, 16'h0000, 8'h02, 8'b0000_0001, 1'b0};
    vecs[5] = '{3, 16'hFF34, 8'h08, 8'b1111_0111, 1'b0};
    vecs[6] = '{1, 16'h0A00, 8'h00, 8'h00, 1'b1};
    vecs[7] = '{6, 16'h08FF, 8'h00, 8'h00, 1'b1};
    vecs[8] = '{4, 16'hFE00, 8'h00, 8'h00, 1'b1};

    repeat (3) tick();
    reset = 1'b0;
    check("rst_pop", 32'(pop), 0);
    check("rst_push", 32'(push), 0);
    check("rst_dpush", 32'(D_push), 0);
    check("rst_busy_err", {busy, err_drop}, 0);
    check("rst_cnt", 32'(drop_cnt), 0);
    check("rst_state", 32'(dbg_state), 0);

    foreach (vecs[v]) begin
      full = vecs[v].full;
      fq[vecs[v].src].push_back(vecs[v].data);
      tick();
      tick();
      check($sformatf("v%0d_pop", v), 32'(pop), 32'(8'b1 << vecs[v].src));
      check($sformatf("v%0d_pop_busy", v), {busy, push}, {1'b1, 8'h00});
      tick();
      if (vecs[v].exp_drop) exp_cnt++;
      check($sformatf("v%0d_push", v), 32'(push), 32'(vecs[v].exp_push));
      check($sformatf("v%0d_err_busy", v), {err_drop, busy}, {vecs[v].exp_drop, ~vecs[v].exp_drop});
      check($sformatf("v%0d_cnt", v), 32'(drop_cnt), 32'(exp_cnt));
      if (!vecs[v].exp_drop) check($sformatf("v%0d_dpush", v), 32'(D_push), 32'(vecs[v].data));
      tick();
      check($sformatf("v%0d_after", v), {push, busy, err_drop}, 0);
      full = '0;
    end

    // Broadcast held off by full[6] for 10 cycles starting at the pop cycle
    full = 8'h40;
    fq[3].push_back(16'hFF12);
    wait_pop(idx, cyc);
    check("bp_grant", 32'(idx), 3);
    for (int k = 1; k <= 10; k++) begin
      tick();
      check($sformatf("bp_hold%0d", k), {push, err_drop}, 0);
      if (k == 10) full = '0;
    end
    tick();
    check("bp_push", 32'(push), 32'h0F7);
    check("bp_dpush", 32'(D_push), 32'hFF12);
    tick();
    check("bp_once", {push, err_drop}, 0);
    repeat (2) tick();

    reset_dut();
    arb_run("rr", 1'b0, 99, 99);
    reset_dut();
    arb_run("fx", 1'b1, 99, 99);
    reset_dut();
    arb_run("sw", 1'b0, 3, 9);

    // Invalid destination, then timeout under sustained backpressure
    reset_dut();
    fq[1].push_back(16'h0A00);
    wait_pop(idx, cyc);
    tick();
    check("inv_err", {err_drop, push}, {1'b1, 8'h00});
    check("inv_cnt", 32'(drop_cnt), 1);
    full = 8'h10;
    fq[1].push_back(16'h0400);
    wait_pop(idx, cyc);
    n = 0;
    seen_push = 1'b0;
    while (n < 100) begin
      tick();
      n++;
      if (push != '0) seen_push = 1'b1;
      if (err_drop) break;
    end
    check("tmo_latency", 32'(n), 65);
    check("tmo_nopush", 32'(seen_push), 0);
    check("tmo_cnt", 32'(drop_cnt), 2);
    full = '0;
    repeat (2) tick();

    // Saturation on the narrow counter
    reset_dut();
    for (int k = 0; k < 5; k++) fq[1].push_back(16'h0A00);
    npulse = 0;
    repeat (30) begin
      tick();
      if (err_drop) npulse++;
    end
    check("sat_pulses", 32'(npulse), 5);
    check("sat_cnt16", 32'(drop_cnt), 5);
    check("sat_cnt2", 32'(drop_cnt_s), 3);

    // Reset while stuck in DELIVER
    full = 8'h08;
    fq[5].push_back(16'h0300);
    wait_pop(idx, cyc);
    check("mid_grant", 32'(idx), 5);
    tick();
    tick();
    check("mid_deliver", {busy, 6'(dbg_state)}, {1'b1, 6'd2});
    reset = 1'b1;
    tick();
    check("mid_rst_outs", {pop, push, busy, err_drop}, 0);
    check("mid_rst_dpush", 32'(D_push), 0);
    check("mid_rst_cnt", {16'(drop_cnt), 14'd0, drop_cnt_s}, 0);
    check("mid_rst_state", 32'(dbg_state), 0);
    reset = 1'b0;
    full = '0;
    for (int i = 0; i < N; i++) fq[i].push_back({8'((i + 1) % N), 8'h5A});
    wait_pop(idx, cyc);
    check("ptr_restart", 32'(idx), 0);
    wait_pop(idx, cyc);
    check("ptr_next", 32'(idx), 1);
    repeat (30) tick();

    check("no_push_pop_overlap", 32'(overlap), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
